// File: rtl/mipi_tx_pkg.sv
// Shared types for the multi-lane D-PHY TX sequencer: FSM states, lane word
// selects, LP line pairs and counter sizing.
package mipi_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LPX, ST_PREP, ST_HS_ZERO, ST_HS_SYNC, ST_HS_DATA, ST_HS_TRAIL, ST_HS_EXIT
  } tx_state_e;

  typedef enum logic [1:0] {W_ZERO, W_SYNC, W_DATA, W_TRAIL} word_sel_e;

  // {dp, dn}
  typedef logic [1:0] lp_pair_t;
  localparam lp_pair_t LP11 = 2'b11;
  localparam lp_pair_t LP01 = 2'b01;
  localparam lp_pair_t LP00 = 2'b00;

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

  // Down-counter loads T-1, so it only needs to hold values below the longest phase.
  function automatic int cnt_bits(int a, int b, int c, int d);
    int m;
    m = max2(max2(a, b), max2(c, d));
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/mipi_tx_lane_ctrl_if.sv
// Payload stream from fabric packet logic into the TX sequencer.
interface mipi_tx_lane_ctrl_if #(
  parameter int LANES = 2,
  parameter int WIDTH = 8
);
  logic [LANES*WIDTH-1:0] TX_DATA;
  logic                   TX_VALID;
  logic                   TX_LAST;
  logic                   TX_READY;

  modport master (output TX_DATA, TX_VALID, TX_LAST, input TX_READY);
  modport slave  (input TX_DATA, TX_VALID, TX_LAST, output TX_READY);
endinterface

// File: rtl/mipi_tx_lane_mux.sv
// Per-lane HS word register: picks zero/sync/payload/trail and remembers the
// MSB of the last transmitted word to build the trail pattern.
module mipi_tx_lane_mux
  import mipi_tx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             act,
  input  word_sel_e        sel,
  input  logic [WIDTH-1:0] sync_word,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] word
);

  logic             last_q;
  logic [WIDTH-1:0] word_d;

  always_comb begin
    word_d = '0;
    if (act) begin
      case (sel)
        W_SYNC:  word_d = sync_word;
        W_DATA:  word_d = data;
        // LSB goes out first, so the trail continues opposite to the final bit sent
        W_TRAIL: word_d = {WIDTH{~last_q}};
        default: word_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word   <= '0;
      last_q <= 1'b0;
    end else begin
      word <= word_d;
      if (act && (sel == W_SYNC || sel == W_DATA)) last_q <= word_d[WIDTH-1];
    end
  end

endmodule

// File: rtl/mipi_tx_lane_ctrl.sv
// Multi-lane D-PHY HS burst sequencer (LP-11 -> LP-01 -> LP-00 -> HS -> LP-11).
// Define MIPI_TX_STATS_EN to add saturating BURST_CNT / UNDERFLOW_CNT outputs.
module mipi_tx_lane_ctrl
  import mipi_tx_pkg::*;
#(
  parameter int          LANES     = 2,
  parameter int          WIDTH     = 8,
  parameter logic [15:0] SYNC_WORD = 16'h00B8,
  parameter int          T_LPX     = 2,
  parameter int          T_PREP    = 2,
  parameter int          T_ZERO    = 6,
  parameter int          T_TRAIL   = 4
) (
  input  logic                   CLK_IN,
  input  logic                   RST,
  input  logic                   PLL_LOCK,
  input  logic [LANES-1:0]       LANE_EN,
  input  logic                   TX_REQ,
  mipi_tx_lane_ctrl_if.slave     tx,
  output logic [LANES*WIDTH-1:0] HS_TX_DATA,
  output logic                   HS_TXD_VALID,
  output logic [LANES-1:0]       HS_EN,
  output logic                   LP_EN,
  output logic [LANES-1:0]       TX_LP_DP,
  output logic [LANES-1:0]       TX_LP_DN,
  output logic                   TX_ODT_EN,
  output logic                   BUSY,
  output logic                   ERR_UNDERFLOW,
  output logic                   ERR_ABORT
`ifdef MIPI_TX_STATS_EN
  ,
  output logic [15:0]            BURST_CNT,
  output logic [15:0]            UNDERFLOW_CNT
`endif
);

  localparam int CW = cnt_bits(T_LPX, T_PREP, T_ZERO, T_TRAIL);

  tx_state_e                   state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [LANES-1:0]            mask_q, mask_d, dp_d, dn_d;
  logic                        ready_q, ready_d, underflow, abort, hs_d, cnt_done;
  word_sel_e                   sel_d;
  logic [LANES-1:0][WIDTH-1:0] data_lanes, word_lanes;

  assign data_lanes  = tx.TX_DATA;
  assign tx.TX_READY = ready_q;
  assign HS_TX_DATA  = word_lanes;
  assign cnt_done    = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_done ? cnt_q : cnt_q - CW'(1);
    mask_d    = mask_q;
    ready_d   = 1'b0;
    underflow = 1'b0;
    abort     = 1'b0;
    if (state_q != ST_IDLE && !PLL_LOCK) begin
      abort   = 1'b1;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:
          if (TX_REQ && PLL_LOCK && LANE_EN[0]) begin
            state_d = ST_LPX;
            cnt_d   = CW'(T_LPX - 1);
            mask_d  = LANE_EN;
          end
        ST_LPX:
          if (cnt_done) begin
            state_d = ST_PREP;
            cnt_d   = CW'(T_PREP - 1);
          end
        ST_PREP:
          if (cnt_done) begin
            state_d = ST_HS_ZERO;
            cnt_d   = CW'(T_ZERO - 1);
          end
        ST_HS_ZERO:
          if (cnt_done) begin
            state_d = ST_HS_SYNC;
            ready_d = 1'b1;
          end
        ST_HS_SYNC, ST_HS_DATA: begin
          // ready_q low here means the TX_LAST word is on the wire this cycle
          if (!ready_q) begin
            state_d = ST_HS_TRAIL;
            cnt_d   = CW'(T_TRAIL - 1);
          end else if (!tx.TX_VALID) begin
            underflow = 1'b1;
            state_d   = ST_HS_TRAIL;
            cnt_d     = CW'(T_TRAIL - 1);
          end else begin
            state_d = ST_HS_DATA;
            ready_d = !tx.TX_LAST;
          end
        end
        ST_HS_TRAIL:
          if (cnt_done) begin
            state_d = ST_HS_EXIT;
            cnt_d   = CW'(T_LPX - 1);
          end
        ST_HS_EXIT:
          if (cnt_done) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state held.
  always_comb begin
    hs_d = state_d inside {ST_HS_ZERO, ST_HS_SYNC, ST_HS_DATA, ST_HS_TRAIL};
    case (state_d)
      ST_HS_SYNC:  sel_d = W_SYNC;
      ST_HS_DATA:  sel_d = W_DATA;
      ST_HS_TRAIL: sel_d = W_TRAIL;
      default:     sel_d = W_ZERO;
    endcase
    dp_d = '1;
    dn_d = '1;
    for (int i = 0; i < LANES; i++) begin
      if (mask_d[i]) begin
        if (state_d == ST_LPX)                 {dp_d[i], dn_d[i]} = LP01;
        else if (state_d == ST_PREP || hs_d)   {dp_d[i], dn_d[i]} = LP00;
      end
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      mask_q        <= '0;
      ready_q       <= 1'b0;
      LP_EN         <= 1'b1;
      HS_EN         <= '0;
      HS_TXD_VALID  <= 1'b0;
      TX_ODT_EN     <= 1'b0;
      TX_LP_DP      <= '1;
      TX_LP_DN      <= '1;
      BUSY          <= 1'b0;
      ERR_UNDERFLOW <= 1'b0;
      ERR_ABORT     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mask_q        <= mask_d;
      ready_q       <= ready_d;
      LP_EN         <= !hs_d;
      HS_EN         <= hs_d ? mask_d : '0;
      HS_TXD_VALID  <= hs_d;
      TX_ODT_EN     <= hs_d;
      TX_LP_DP      <= dp_d;
      TX_LP_DN      <= dn_d;
      BUSY          <= (state_d != ST_IDLE);
      ERR_UNDERFLOW <= underflow;
      ERR_ABORT     <= abort;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mipi_tx_lane_mux #(.WIDTH(WIDTH)) u_mux (
      .clk       (CLK_IN),
      .rst       (RST),
      .act       (mask_d[i]),
      .sel       (sel_d),
      .sync_word (SYNC_WORD[WIDTH-1:0]),
      .data      (data_lanes[i]),
      .word      (word_lanes[i])
    );
  end

`ifdef MIPI_TX_STATS_EN
  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      BURST_CNT     <= '0;
      UNDERFLOW_CNT <= '0;
    end else begin
      if (state_q == ST_HS_TRAIL && state_d == ST_HS_EXIT && BURST_CNT != 16'hFFFF)
        BURST_CNT <= BURST_CNT + 16'd1;
      if (underflow && UNDERFLOW_CNT != 16'hFFFF)
        UNDERFLOW_CNT <= UNDERFLOW_CNT + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mipi_tx_lane_ctrl.sv
// Directed cycle-table bench for mipi_tx_lane_ctrl (2 lanes x 8 bits, default timing).
module tb_mipi_tx_lane_ctrl;

  localparam logic [15:0] A = 16'hA55A, B = 16'hC315, C = 16'h7F81, SYN = 16'hB8B8;

  typedef enum logic [2:0] {PH_I, PH_X, PH_P, PH_H, PH_E} ph_e;

  typedef struct {
    logic        rst, req, pll;
    logic [1:0]  en;
    logic        valid, last;
    logic [15:0] din;
    ph_e         ph;
    logic [1:0]  m;
    logic        cd;
    logic [15:0] dat;
    logic        rdy, eu, ea;
  } vec_t;

  logic clk = 1'b0;
  logic rst, pll, req;
  logic [1:0]  en;
  logic [15:0] hs_data;
  logic        hs_vld, lp_en, odt, busy, eu, ea;
  logic [1:0]  hs_en, dp, dn;
`ifdef MIPI_TX_STATS_EN
  logic [15:0] bcnt, ucnt;
`endif

  int checks = 0;
  int failures = 0;
  vec_t vq[$];
  vec_t v;

  always #5 clk = ~clk;

  mipi_tx_lane_ctrl_if #(.LANES(2), .WIDTH(8)) tx_if();

  mipi_tx_lane_ctrl #(.LANES(2), .WIDTH(8)) dut (
    .CLK_IN        (clk),
    .RST           (rst),
    .PLL_LOCK      (pll),
    .LANE_EN       (en),
    .TX_REQ        (req),
    .tx            (tx_if),
    .HS_TX_DATA    (hs_data),
    .HS_TXD_VALID  (hs_vld),
    .HS_EN         (hs_en),
    .LP_EN         (lp_en),
    .TX_LP_DP      (dp),
    .TX_LP_DN      (dn),
    .TX_ODT_EN     (odt),
    .BUSY          (busy),
    .ERR_UNDERFLOW (eu),
    .ERR_ABORT     (ea)
`ifdef MIPI_TX_STATS_EN
    ,
    .BURST_CNT     (bcnt),
    .UNDERFLOW_CNT (ucnt)
`endif
  );

  function automatic logic [15:0] z(input logic b);
    return {15'b0, b};
  endfunction

  task automatic chk(input string nm, input int row, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  task automatic add(input logic r, q, p, input logic [1:0] e, input logic vl, ls,
                     input logic [15:0] d, input ph_e ph, input logic [1:0] m, input logic cd,
                     input logic [15:0] dat, input logic rdy, erru, erra);
    vec_t t;
    t.rst = r; t.req = q; t.pll = p; t.en = e; t.valid = vl; t.last = ls; t.din = d;
    t.ph = ph; t.m = m; t.cd = cd; t.dat = dat; t.rdy = rdy; t.eu = erru; t.ea = erra;
    vq.push_back(t);
  endtask

  // Request cycle, LP-01 x2, LP-00 x2, then nz cycles of HS-zero.
  task automatic pre(input logic [1:0] en0, m, en1, input int nz);
    add(0, 1, 1, en0, 0, 0, 16'h0, PH_I, m, 0, 16'h0, 0, 0, 0);
    for (int k = 0; k < 2; k++) add(0, 0, 1, en1, 0, 0, 16'h0, PH_X, m, 0, 16'h0, 0, 0, 0);
    for (int k = 0; k < 2; k++) add(0, 0, 1, en1, 0, 0, 16'h0, PH_P, m, 0, 16'h0, 0, 0, 0);
    for (int k = 0; k < nz; k++) add(0, 0, 1, en1, 0, 0, 16'h0, PH_H, m, 1, 16'h0, 0, 0, 0);
  endtask

  // Four trail cycles, two LP-11 exit cycles, back in IDLE.
  task automatic tail(input logic [1:0] m, input logic [15:0] tr, input logic eu0);
    for (int k = 0; k < 4; k++)
      add(0, 0, 1, 2'b11, 0, 0, 16'h0, PH_H, m, 1, tr, 0, (k == 0) ? eu0 : 1'b0, 0);
    for (int k = 0; k < 2; k++) add(0, 0, 1, 2'b11, 0, 0, 16'h0, PH_E, m, 0, 16'h0, 0, 0, 0);
    add(0, 0, 1, 2'b11, 0, 0, 16'h0, PH_I, m, 0, 16'h0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0]  care, edp, edn;
    logic [15:0] dm;
    int n, eu_n;

    // normal 3-word burst, both lanes
    pre(2'b11, 2'b11, 2'b11, 6);
    add(0, 0, 1, 2'b11, 1, 0, A,     PH_H, 2'b11, 1, SYN, 1, 0, 0);
    add(0, 0, 1, 2'b11, 1, 0, B,     PH_H, 2'b11, 1, A,   1, 0, 0);
    add(0, 0, 1, 2'b11, 1, 1, C,     PH_H, 2'b11, 1, B,   1, 0, 0);
    add(0, 0, 1, 2'b11, 0, 0, 16'h0, PH_H, 2'b11, 1, C,   0, 0, 0);
    tail(2'b11, 16'hFF00, 0);
    // lane 1 disabled at request; LANE_EN changes afterwards must not matter
    pre(2'b01, 2'b01, 2'b11, 6);
    add(0, 0, 1, 2'b11, 1, 0, A,     PH_H, 2'b01, 1, SYN, 1, 0, 0);
    add(0, 0, 1, 2'b11, 1, 0, B,     PH_H, 2'b01, 1, A,   1, 0, 0);
    add(0, 0, 1, 2'b11, 1, 1, C,     PH_H, 2'b01, 1, B,   1, 0, 0);
    add(0, 0, 1, 2'b11, 0, 0, 16'h0, PH_H, 2'b01, 1, C,   0, 0, 0);
    tail(2'b01, 16'hFF00, 0);
    // underflow at cycle 13: trail built from B
    pre(2'b11, 2'b11, 2'b11, 6);
    add(0, 0, 1, 2'b11, 1, 0, A,     PH_H, 2'b11, 1, SYN, 1, 0, 0);
    add(0, 0, 1, 2'b11, 1, 0, B,     PH_H, 2'b11, 1, A,   1, 0, 0);
    add(0, 0, 1, 2'b11, 0, 0, 16'h0, PH_H, 2'b11, 1, B,   1, 0, 0);
    tail(2'b11, 16'h00FF, 1);
    // PLL loss at cycle 7 in HS-zero
    pre(2'b11, 2'b11, 2'b11, 2);
    add(0, 0, 0, 2'b11, 0, 0, 16'h0, PH_H, 2'b11, 1, 16'h0, 0, 0, 0);
    add(0, 0, 1, 2'b11, 0, 0, 16'h0, PH_I, 2'b11, 0, 16'h0, 0, 0, 1);
    add(0, 0, 1, 2'b11, 0, 0, 16'h0, PH_I, 2'b11, 0, 16'h0, 0, 0, 0);
    // reset at cycle 12 mid-payload
    pre(2'b11, 2'b11, 2'b11, 6);
    add(0, 0, 1, 2'b11, 1, 0, A,     PH_H, 2'b11, 1, SYN,   1, 0, 0);
    add(1, 0, 1, 2'b11, 1, 0, B,     PH_H, 2'b11, 1, A,     1, 0, 0);
    add(0, 0, 1, 2'b11, 1, 0, C,     PH_I, 2'b11, 1, 16'h0, 0, 0, 0);
    add(0, 0, 1, 2'b11, 0, 0, 16'h0, PH_I, 2'b11, 1, 16'h0, 0, 0, 0);
    // rejected requests: lane 0 disabled, then PLL unlocked
    for (int k = 0; k < 3; k++) add(0, 1, 1, 2'b10, 0, 0, 16'h0, PH_I, 2'b11, 0, 16'h0, 0, 0, 0);
    for (int k = 0; k < 3; k++) add(0, 1, 0, 2'b11, 0, 0, 16'h0, PH_I, 2'b11, 0, 16'h0, 0, 0, 0);
    add(0, 0, 1, 2'b11, 0, 0, 16'h0, PH_I, 2'b11, 0, 16'h0, 0, 0, 0);

    rst = 1'b1; req = 1'b0; pll = 1'b1; en = 2'b11;
    tx_if.TX_VALID = 1'b0; tx_if.TX_LAST = 1'b0; tx_if.TX_DATA = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_lp_en", -1, z(lp_en), 16'h1);
    chk("rst_lp_dp", -1, {14'b0, dp}, 16'h3);
    chk("rst_lp_dn", -1, {14'b0, dn}, 16'h3);
    chk("rst_hs_en", -1, {14'b0, hs_en}, 16'h0);
    chk("rst_hs_data", -1, hs_data, 16'h0);
    chk("rst_misc", -1, {10'b0, hs_vld, tx_if.TX_READY, odt, busy, eu, ea}, 16'h0);

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      @(posedge clk); #1;
      rst = v.rst; req = v.req; pll = v.pll; en = v.en;
      tx_if.TX_VALID = v.valid; tx_if.TX_LAST = v.last; tx_if.TX_DATA = v.din;
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
        care[l] = !(v.ph == PH_H && v.m[l]);
        edp[l]  = !(v.m[l] && (v.ph == PH_X || v.ph == PH_P));
        edn[l]  = !(v.m[l] && v.ph == PH_P);
      end
      dm = {{8{v.m[1]}}, {8{v.m[0]}}};
      chk("busy",     i, z(busy),   z(v.ph != PH_I));
      chk("lp_en",    i, z(lp_en),  z(v.ph != PH_H));
      chk("hs_en",    i, {14'b0, hs_en}, (v.ph == PH_H) ? {14'b0, v.m} : 16'h0);
      chk("odt",      i, z(odt),    z(v.ph == PH_H));
      chk("hs_vld",   i, z(hs_vld), z(v.ph == PH_H));
      chk("lp_dp",    i, {14'b0, dp & care}, {14'b0, edp & care});
      chk("lp_dn",    i, {14'b0, dn & care}, {14'b0, edn & care});
      chk("tx_ready", i, z(tx_if.TX_READY), z(v.rdy));
      if (v.cd) chk("hs_data", i, hs_data & dm, v.dat & dm);
      chk("err_uf",   i, z(eu), z(v.eu));
      chk("err_abort", i, z(ea), z(v.ea));
    end

    // Underflow straight out of HS-sync: 2+2+6+1+4+2 = 17 busy cycles, one pulse.
    @(posedge clk); #1;
    req = 1'b1; pll = 1'b1; en = 2'b11; tx_if.TX_VALID = 1'b0;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk("seq_busy_rise", 0, z(busy), 16'h1);
    n = 1; eu_n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      if (busy) n++;
      if (eu) eu_n++;
    end
    chk("seq_busy_len", 0, 16'(n), 16'd17);
    chk("seq_uf_pulses", 0, 16'(eu_n), 16'd1);

`ifdef MIPI_TX_STATS_EN
    chk("burst_cnt", 0, bcnt, 16'd1);
    chk("underflow_cnt", 0, ucnt, 16'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mipi_tx_lane_ctrl.md
Name: mipi_tx_lane_ctrl

Overview:
Multi-lane MIPI D-PHY transmit sequencer and successor to the single-lane TX wrapper. It generalises to LANES lanes of WIDTH-bit words. It owns the full HS burst sequence (LP-11 → LP-01 → LP-00 → HS-zero → sync → payload → trail → LP-11) with parametrised timing, per-lane enable, underflow handling and PLL-loss abort. It sits between fabric packet logic and the per-lane serializer/LP driver primitives.

Parameters:
LANES, 2, number of data lanes (1-4)
WIDTH, 8, serializer word width (3-10)
SYNC_WORD, 8'hB8, HS sync word (WIDTH bits; bits above WIDTH ignored)
T_LPX, 2, CLK_IN cycles in LP-01 and in exit LP-11 (≥1)
T_PREP, 2, cycles in LP-00 (≥1)
T_ZERO, 6, cycles of HS-zero (≥1)
T_TRAIL, 4, cycles of HS-trail (≥1)

Ports:
CLK_IN  in  1  fabric core clock
RST  in  1  synchronous reset, active-high
PLL_LOCK  in  1  serializer PLL lock
LANE_EN  in  LANES  per-lane enable, sampled on IDLE→LPX
TX_REQ  in  1  burst request, level
TX_DATA  in  LANES*WIDTH  payload; lane i = bits [i*WIDTH +: WIDTH]
TX_VALID  in  1  payload valid
TX_LAST  in  1  last payload word of burst
TX_READY  out  1  payload accept
HS_TX_DATA  out  LANES*WIDTH  word to serializers
HS_TXD_VALID  out  1  load word
HS_EN  out  LANES  per-lane HS enable
LP_EN  out  1  LP drive enable
TX_LP_DP  out  LANES  LP positive
TX_LP_DN  out  LANES  LP negative
TX_ODT_EN  out  1  termination enable
BUSY  out  1  high outside IDLE
ERR_UNDERFLOW  out  1  one-cycle pulse
ERR_ABORT  out  1  one-cycle pulse

Behaviour:
- All outputs registered. Outputs reflect the state held in the same cycle.
- Reset values: state IDLE, LP_EN=1, TX_LP_DP/DN all 1 (LP-11), HS_EN=0, HS_TX_DATA=0, HS_TXD_VALID=0, TX_READY=0, TX_ODT_EN=0, BUSY=0, errors 0. Reset mid-burst returns to this state at the next edge with no trail.
- States and durations: IDLE; LPX (T_LPX); PREP (T_PREP); HS_ZERO (T_ZERO); HS_SYNC (1); HS_DATA (variable); HS_TRAIL (T_TRAIL); HS_EXIT (T_LPX). Each timed state lasts exactly its count.
- IDLE→LPX when TX_REQ & PLL_LOCK & LANE_EN[0]. Otherwise the request is ignored. Active lane mask is latched at this transition.
- LP encoding on active lanes: LPX=LP-01, PREP=LP-00. IDLE/HS_EXIT=LP-11. Inactive lanes stay LP-11 with HS_EN=0 throughout.
- HS_ZERO..HS_TRAIL: LP_EN=0, HS_EN=active mask, TX_ODT_EN=1, HS_TXD_VALID=1.
- Otherwise LP_EN=1, HS_EN=0, HS_TXD_VALID=0. LP_EN and any HS_EN bit are never high together.
- HS words: HS_ZERO=all 0; HS_SYNC=SYNC_WORD every active lane; HS_DATA=accepted payload.
- HS_TRAIL word: every bit = ~bit[WIDTH-1] of that lane's last transmitted word (LSB serialised first). If no payload was sent, the sync word is the last transmitted word.
- TX_READY=1 in HS_SYNC and in HS_DATA until TX_LAST is accepted. A word accepted at cycle k is output at k+1.
- TX_LAST accepted at k: TX_READY=0 at k+1 while the last word is output; HS_TRAIL starts at k+2.
- Underflow: TX_READY=1 & TX_VALID=0 at k → HS_TRAIL from k+1, ERR_UNDERFLOW=1 at k+1.
- PLL_LOCK=0 in any non-IDLE state → IDLE at the next edge (LP-11, HS_EN=0), ERR_ABORT=1 that cycle. Takes priority over underflow and last.
- TX_REQ is only examined in IDLE; deasserting it mid-burst has no effect.
- Default latency: REQ at cycle 0 → LPX 1-2, PREP 3-4, ZERO 5-10, SYNC 11, first payload out at 12.

Optional Feature:
MIPI_TX_STATS_EN
- Defined: adds outputs BURST_CNT[15:0] (completed bursts, increments on HS_EXIT entry) and UNDERFLOW_CNT[15:0]. Both saturate at 16'hFFFF and clear on RST.
- Undefined: ports absent, no counter logic.

Decomposition:
- Package mipi_tx_pkg: state enum, LP pair constants (LP11/LP01/LP00), width helpers.
- Sub-module mipi_tx_lane_mux, instantiated once per lane: holds the lane's word register and last-bit register, and selects zero/sync/data/trail.

Test Plan:
- Defaults, LANE_EN=2'b11, 3 words (A,B,C last) accepted at cycles 11-13 → outputs SYNC@11, A@12, B@13, C@14; TX_READY=0@14; trail 15-18 = ~C[7]; LP-11@19-20; IDLE@21; BUSY high 1-20.
- LANE_EN=2'b01 → lane1 LP-11 and HS_EN[1]=0 for the whole burst; lane0 as above.
- TX_VALID=0 at cycle 13 → trail from 14 using ~B[7]; ERR_UNDERFLOW pulse @14.
- PLL_LOCK drops at cycle 7 (HS_ZERO) → cycle 8 IDLE, LP_EN=1, HS_EN=0, ERR_ABORT pulse @8.
- RST high at cycle 12 → all outputs at reset values next cycle, no trail.
- TX_REQ with LANE_EN[0]=0 or PLL_LOCK=0 → stays IDLE, BUSY=0.
